// File: rtl/vp_pattern_gen.sv
// Video test-pattern source: emits a vs/de/8-bit grey raster with programmable blanking.
// Frames always run to completion; pattern and level are frozen per frame.
module vp_pattern_gen #(
    parameter logic [10:0] IMG_HDISP = 11'd1280,
    parameter logic [10:0] IMG_VDISP = 11'd720,
    parameter logic [10:0] H_BLANK   = 11'd160,
    parameter logic [10:0] V_BLANK   = 11'd30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic [1:0]  pattern,
    input  logic [7:0]  level,
    output logic        post_vs,
    output logic        post_de,
    output logic [7:0]  post_img,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] H_TOTAL = IMG_HDISP + H_BLANK;
    localparam logic [10:0] V_TOTAL = IMG_VDISP + V_BLANK;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic [1:0]  pat_r;
    logic [7:0]  lvl_r;

    logic        h_end;
    logic        v_end;
    logic        frame_wrap;
    logic        active;
    logic        at_origin;

    logic [1:0]  pat_eff;
    logic [7:0]  lvl_eff;
    logic [7:0]  pix_c;
    logic        vs_c;
    logic        de_c;
    logic [7:0]  img_c;
    logic        done_c;

    assign h_end      = (hcnt == H_TOTAL - 11'd1);
    assign v_end      = (vcnt == V_TOTAL - 11'd1);
    assign frame_wrap = h_end && v_end;
    assign active     = (state != IDLE);
    assign at_origin  = (state == RUN) && (hcnt == 11'd0) && (vcnt == 11'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Leaving RUN mid-frame goes through DRAIN so the frame is never cut short.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (EN) state_nxt = RUN;
            RUN:     if (!EN) state_nxt = frame_wrap ? IDLE : DRAIN;
            DRAIN:   if (frame_wrap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (state == IDLE)) begin
            hcnt <= 11'd0;
            vcnt <= 11'd0;
        end else if (h_end) begin
            hcnt <= 11'd0;
            vcnt <= v_end ? 11'd0 : vcnt + 11'd1;
        end else begin
            hcnt <= hcnt + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r     <= 2'd0;
            lvl_r     <= 8'd0;
            frame_cnt <= 16'd0;
        end else begin
            if (at_origin) begin
                pat_r <= pattern;
                lvl_r <= level;
            end
            if (active && frame_wrap) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // The first pixel of a frame uses the live inputs, which are being latched on the same edge.
    always_comb begin
        pat_eff = at_origin ? pattern : pat_r;
        lvl_eff = at_origin ? level : lvl_r;
        case (pat_eff)
            2'd0:    pix_c = lvl_eff;
            2'd1:    pix_c = hcnt[7:0] + frame_cnt[7:0];
            2'd2:    pix_c = vcnt[7:0];
            default: pix_c = (hcnt[3] ^ vcnt[3]) ? 8'hFF : 8'h00;
        endcase
        vs_c   = active && (vcnt < IMG_VDISP);
        de_c   = vs_c && (hcnt < IMG_HDISP);
        img_c  = de_c ? pix_c : 8'h00;
        done_c = active && frame_wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            post_vs    <= 1'b0;
            post_de    <= 1'b0;
            post_img   <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            post_vs    <= vs_c;
            post_de    <= de_c;
            post_img   <= img_c;
            frame_done <= done_c;
        end
    end

endmodule
